// File: rtl/alu4_rr_sched.sv
// Round-robin scheduler that shares one external 4-bit combinational ALU between two
// requesters. It registers the winner's operands, waits ALU_LAT settle cycles, then returns a tagged result.
module alu4_rr_sched #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [1:0] op0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    output logic       ack0,
    input  logic       req1,
    input  logic [1:0] op1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       ack1,
    output logic [1:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_y,
    input  logic       alu_co,
    output logic [3:0] res,
    output logic       res_co,
    output logic       res_id,
    output logic       res_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b11;
    localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       last_q;
    logic       win_q;
    logic       win_d;

    // A lone request wins outright; on a tie the side that did not win last goes.
    assign win_d = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            alu_op    <= 2'd0;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            res       <= 4'd0;
            res_co    <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            res_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        win_q   <= win_d;
                        alu_op  <= win_d ? op1 : op0;
                        alu_a   <= win_d ? a1 : a0;
                        alu_b   <= win_d ? b1 : b0;
                        ack0    <= ~win_d;
                        ack1    <= win_d;
                        busy    <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        res       <= alu_y;
                        // Carry-out is only meaningful for ADD.
                        res_co    <= (alu_op == OP_ADD) ? alu_co : 1'b0;
                        res_id    <= win_q;
                        last_q    <= win_q;
                        res_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_rr_sched.sv
// Bench for alu4_rr_sched: four instances (ALU_LAT=1..4) share stimulus; each scenario
// watches one instance against a transaction-level model of arbitration, latency and results.
module tb_alu4_rr_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req0 = 1'b0, req1 = 1'b0, force_co = 1'b0;
    logic [1:0] op0 = 2'd0, op1 = 2'd0;
    logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;

    logic [3:0] ack0_w, ack1_w, busy_w, rv_w, rco_w, rid_w, aco_w;
    logic [1:0] aop_w[4];
    logic [3:0] aa_w[4], ab_w[4], ay_w[4], res_w[4];
    logic [4:0] sum_w[4];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        alu4_rr_sched #(.ALU_LAT(g + 1)) dut (
            .clk(clk), .rst(rst),
            .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0_w[g]),
            .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1_w[g]),
            .alu_op(aop_w[g]), .alu_a(aa_w[g]), .alu_b(ab_w[g]),
            .alu_y(ay_w[g]), .alu_co(aco_w[g]),
            .res(res_w[g]), .res_co(rco_w[g]), .res_id(rid_w[g]),
            .res_valid(rv_w[g]), .busy(busy_w[g])
        );
        // External ALU: carry line always shows the adder carry, even for logic ops.
        assign sum_w[g] = {1'b0, aa_w[g]} + {1'b0, ab_w[g]};
        assign ay_w[g]  = (aop_w[g] == 2'd0) ? (aa_w[g] ^ ab_w[g]) :
                          (aop_w[g] == 2'd1) ? (aa_w[g] & ab_w[g]) :
                          (aop_w[g] == 2'd2) ? (aa_w[g] | ab_w[g]) : sum_w[g][3:0];
        assign aco_w[g] = sum_w[g][4] | force_co;
    end

    // Expected {res_co, res}: integer arithmetic, carry exists only for ADD.
    function automatic logic [4:0] expect_res(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int s;
        case (op)
            2'd0: s = int'(a ^ b);
            2'd1: s = int'(a & b);
            2'd2: s = int'(a | b);
            default: s = int'(a) + int'(b);
        endcase
        return 5'(s);
    endfunction

    function automatic logic [19:0] snap(input int s);
        return {ack0_w[s], ack1_w[s], aop_w[s], aa_w[s], ab_w[s], res_w[s],
                rco_w[s], rid_w[s], rv_w[s], busy_w[s]};
    endfunction

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; force_co = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            total++;
            if (snap(s) !== 20'h0) begin
                bad++;
                $display("FAIL reset_outputs lat=%0d: got %h want 0", s + 1, snap(s));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_midwait();
        int seen;
        do_reset();
        req0 = 1'b1; op0 = 2'd3; a0 = 4'd9; b0 = 4'd9;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (snap(3) !== 20'h0) begin
            bad++;
            $display("FAIL midwait_reset: got %h want 0", snap(3));
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rv_w[3]) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midwait_no_result: got %0d pulses want 0", seen);
        end
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        total++;
        if ({ack0_w[3], ack1_w[3]} !== 2'b10) begin
            bad++;
            $display("FAIL midwait_tie_after_reset: got %b want 10", {ack0_w[3], ack1_w[3]});
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1'b1; op0 = 2'd3; a0 = 4'b0111; b0 = 4'b0011;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req0 = 1'b0;
                total++;
                if ({ack0_w[0], ack1_w[0], aop_w[0], aa_w[0], ab_w[0]} !== {2'b10, 2'd3, 4'b0111, 4'b0011}) begin
                    bad++;
                    $display("FAIL single_issue: got ack=%b%b op=%0d a=%h b=%h want ack=10 op=3 a=7 b=3",
                             ack0_w[0], ack1_w[0], aop_w[0], aa_w[0], ab_w[0]);
                end
            end
            total++;
            if ({busy_w[0], rv_w[0]} !== {k != 4, k == 3}) begin
                bad++;
                $display("FAIL single_busy_valid k=%0d: got %b want %b", k, {busy_w[0], rv_w[0]}, {k != 4, k == 3});
            end
            if (k == 3) begin
                total++;
                if ({res_w[0], rco_w[0], rid_w[0]} !== {4'b1010, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL single_result: got res=%b co=%b id=%b want 1010 0 0", res_w[0], rco_w[0], rid_w[0]);
                end
            end
        end
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; op0 = 2'd0; op1 = 2'd0;
        a0 = 4'b1100; b0 = 4'b1010; a1 = 4'b0101; b1 = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            @(negedge clk);
            while (!rv_w[0] && n < 20) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (!rv_w[0]) begin
                bad++;
                $display("FAIL tie_timeout i=%0d: got no res_valid want pulse", i);
            end else if ({rid_w[0], res_w[0]} !== {1'(i % 2), (i % 2) ? 4'b0000 : 4'b0110}) begin
                bad++;
                $display("FAIL tie_order i=%0d: got id=%b res=%b want id=%0d", i, rid_w[0], res_w[0], i % 2);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_carry();
        int n;
        do_reset();
        req1 = 1'b1; op1 = 2'd3; a1 = 4'b1111; b1 = 4'b0001;
        @(negedge clk);
        op1 = 2'd2;
        force_co = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            @(negedge clk);
            while (!rv_w[2] && n < 20) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (!rv_w[2]) begin
                bad++;
                $display("FAIL carry_timeout i=%0d: got no res_valid want pulse", i);
            end else if ({res_w[2], rco_w[2], rid_w[2]} !== ((i == 0) ? {4'b0000, 1'b1, 1'b1} : {4'b1111, 1'b0, 1'b1})) begin
                bad++;
                $display("FAIL carry_mask i=%0d: got res=%b co=%b id=%b", i, res_w[2], rco_w[2], rid_w[2]);
            end
        end
        req1 = 1'b0; force_co = 1'b0;
    endtask

    task automatic test_latency();
        logic [1:0] eop;
        logic [3:0] ea, eb;
        logic [4:0] er;
        for (int s = 0; s < 4; s++) begin
            do_reset();
            eop = 2'($urandom_range(0, 3)); ea = 4'($urandom); eb = 4'($urandom);
            er = expect_res(eop, ea, eb);
            req0 = 1'b1; op0 = eop; a0 = ea; b0 = eb;
            for (int k = 1; k <= s + 3; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    req0 = 1'b0; op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
                end
                total++;
                if (rv_w[s] !== (k == s + 3)) begin
                    bad++;
                    $display("FAIL latency lat=%0d k=%0d: got valid=%b want %b", s + 1, k, rv_w[s], k == s + 3);
                end
                total++;
                if ({aop_w[s], aa_w[s], ab_w[s]} !== {eop, ea, eb}) begin
                    bad++;
                    $display("FAIL alu_stable lat=%0d k=%0d: got %h want %h", s + 1, k,
                             {aop_w[s], aa_w[s], ab_w[s]}, {eop, ea, eb});
                end
                if (k == s + 3) begin
                    total++;
                    if ({rco_w[s], res_w[s]} !== er) begin
                        bad++;
                        $display("FAIL latency_result lat=%0d: got %b want %b", s + 1, {rco_w[s], res_w[s]}, er);
                    end
                end
            end
        end
    endtask

    task automatic test_late_request();
        do_reset();
        req0 = 1'b1; op0 = 2'd1; a0 = 4'hF; b0 = 4'h3;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) req0 = 1'b0;
            if (k == 3) begin
                req1 = 1'b1; op1 = 2'd0; a1 = 4'h6; b1 = 4'h3;
            end
            if (k == 4) req0 = 1'b1;
            if (k == 5) req0 = 1'b0;
            if (k == 8) req1 = 1'b0;
            total++;
            if ({ack0_w[3], ack1_w[3], rv_w[3]} !== {k == 1, k == 8, (k == 6) || (k == 13)}) begin
                bad++;
                $display("FAIL late_req k=%0d: got ack0/ack1/valid=%b want %b", k,
                         {ack0_w[3], ack1_w[3], rv_w[3]}, {k == 1, k == 8, (k == 6) || (k == 13)});
            end
            if (k == 13) begin
                total++;
                if ({rid_w[3], res_w[3]} !== {1'b1, 4'h5}) begin
                    bad++;
                    $display("FAIL late_req_result: got id=%b res=%h want id=1 res=5", rid_w[3], res_w[3]);
                end
            end
        end
    endtask

    task automatic test_random();
        int s, lat;
        logic last, w, p0, p1, first;
        logic [1:0] eop;
        logic [3:0] ea, eb;
        logic [4:0] er;
        s = $urandom_range(0, 3);
        lat = s + 1;
        do_reset();
        last = 1'b1; p0 = 1'b0; p1 = 1'b0; first = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1'b1; op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1'b1; op1 = 2'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            end
            if (!p0 && !p1) begin
                p0 = 1'b1; op0 = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
            end
            req0 = p0; req1 = p1;
            if (!first) @(negedge clk);
            first = 1'b0;
            w   = (p0 && p1) ? ~last : p1;
            eop = w ? op1 : op0;
            ea  = w ? a1 : a0;
            eb  = w ? b1 : b0;
            er  = expect_res(eop, ea, eb);
            for (int k = 1; k <= lat + 2; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    total++;
                    if ({ack0_w[s], ack1_w[s], busy_w[s], aop_w[s], aa_w[s], ab_w[s]} !== {~w, w, 1'b1, eop, ea, eb}) begin
                        bad++;
                        $display("FAIL rand_issue t=%0d: got ack=%b%b op=%0d a=%h b=%h want ack=%b%b op=%0d a=%h b=%h",
                                 t, ack0_w[s], ack1_w[s], aop_w[s], aa_w[s], ab_w[s], ~w, w, eop, ea, eb);
                    end
                    if (w) begin
                        p1 = 1'b0; req1 = 1'b0; a1 = 4'($urandom);
                    end else begin
                        p0 = 1'b0; req0 = 1'b0; a0 = 4'($urandom);
                    end
                end else if (k <= lat + 1) begin
                    total++;
                    if ({ack0_w[s], ack1_w[s], rv_w[s]} !== 3'b000) begin
                        bad++;
                        $display("FAIL rand_wait t=%0d k=%0d: got %b want 000", t, k, {ack0_w[s], ack1_w[s], rv_w[s]});
                    end
                end else begin
                    total++;
                    if ({rv_w[s], rid_w[s], rco_w[s], res_w[s]} !== {1'b1, w, er}) begin
                        bad++;
                        $display("FAIL rand_result t=%0d: got v=%b id=%b co/res=%b want v=1 id=%b co/res=%b",
                                 t, rv_w[s], rid_w[s], {rco_w[s], res_w[s]}, w, er);
                    end
                    last = w;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_carry();
        test_latency();
        test_late_request();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
